// File: rtl/verificador_senha_pkg.sv
// rtl/verificador_senha_pkg.sv - shared types and nibble codes for the password checker
package verificador_senha_pkg;

  localparam int N_NIB = 20;

  // Nibble 0 is the most recently typed digit.
  typedef logic [N_NIB-1:0][3:0] senhaPac_t;

  localparam logic [3:0] NIB_VAZIO   = 4'hF;
  localparam logic [3:0] NIB_TIMEOUT = 4'hE;
  localparam logic [3:0] NIB_CFG     = 4'hB;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    ABERTO = 2'd2,
    BLOQ   = 2'd3
  } verif_estado_t;

  function automatic logic todos_iguais(input senhaPac_t v, input logic [3:0] nib);
    return (v == {N_NIB{nib}});
  endfunction

endpackage

// File: rtl/verificador_senha_comparador.sv
// rtl/verificador_senha_comparador.sv - length/format check and slot match of a latched entry
module senha_comparador
  import verificador_senha_pkg::*;
#(
  parameter int N_SENHAS = 4,
  parameter int MIN_DIG  = 4,
  parameter int MAX_DIG  = 12
) (
  input  senhaPac_t                i_valor,
  input  senhaPac_t [N_SENHAS-1:0] i_senhas,
  input  logic      [N_SENHAS-1:0] i_ativas,
  output logic                     o_match,
  output logic                     o_malformado
);

  localparam logic [4:0] L_MIN = 5'(MIN_DIG);
  localparam logic [4:0] L_MAX = 5'(MAX_DIG);

  logic [4:0] w_len;
  logic       w_fim;
  logic       w_lixo;
  logic       w_igual;

  // Length is the first F position; any digit after it makes the entry malformed.
  always_comb begin
    w_len  = 5'(N_NIB);
    w_fim  = 1'b0;
    w_lixo = 1'b0;
    for (int i = 0; i < N_NIB; i++) begin
      if (i_valor[i] == NIB_VAZIO) begin
        if (!w_fim) w_len = 5'(i);
        w_fim = 1'b1;
      end else if (w_fim) begin
        w_lixo = 1'b1;
      end
    end
  end

  always_comb begin
    w_igual = 1'b0;
    for (int s = 0; s < N_SENHAS; s++) begin
      if (i_ativas[s] && (i_senhas[s] == i_valor)) w_igual = 1'b1;
    end
  end

  assign o_malformado = w_lixo | (w_len < L_MIN) | (w_len > L_MAX);
  assign o_match      = w_igual & ~o_malformado;

endmodule

// File: rtl/verificador_senha.sv
// rtl/verificador_senha.sv - password checker FSM with open window, failure count and lockout
module verificador_senha
  import verificador_senha_pkg::*;
#(
  parameter int N_SENHAS = 4,
  parameter int MIN_DIG  = 4,
  parameter int MAX_DIG  = 12,
  parameter int MAX_TENT = 3,
  parameter int T_ABERTO = 5000,
  parameter int T_BLOQ   = 30000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  input  senhaPac_t                         digitos_value,
  input  logic                              digitos_valid,
  input  senhaPac_t [N_SENHAS-1:0]          senhas,
  input  logic      [N_SENHAS-1:0]          senhas_ativas,
  output logic                              tranca_aberta,
  output logic                              bloqueado,
  output logic                              bip,
  output logic                              setup_req,
  output logic [$clog2(MAX_TENT+1)-1:0]     tentativas
);

  localparam int T_MAX = (T_BLOQ > T_ABERTO) ? T_BLOQ : T_ABERTO;
  localparam int TW    = $clog2(T_MAX + 1);
  localparam int CW    = $clog2(MAX_TENT + 1);
  localparam logic [CW-1:0] TENT_MAX = CW'(MAX_TENT);

  verif_estado_t r_estado;
  verif_estado_t w_prox;
  logic [TW-1:0] r_timer;
  senhaPac_t     r_latch;
  logic [CW-1:0] r_tent;
  logic          r_bip;
  logic          r_setup;

  logic          w_match;
  logic          w_malformado;
  logic          w_eh_cfg;
  logic          w_especial;
  logic [CW-1:0] w_tent_inc;

  senha_comparador #(
    .N_SENHAS (N_SENHAS),
    .MIN_DIG  (MIN_DIG),
    .MAX_DIG  (MAX_DIG)
  ) u_comp (
    .i_valor      (r_latch),
    .i_senhas     (senhas),
    .i_ativas     (senhas_ativas),
    .o_match      (w_match),
    .o_malformado (w_malformado)
  );

  assign w_eh_cfg   = todos_iguais(digitos_value, NIB_CFG);
  assign w_especial = w_eh_cfg | todos_iguais(digitos_value, NIB_TIMEOUT)
                    | todos_iguais(digitos_value, NIB_VAZIO);
  assign w_tent_inc = (r_tent == TENT_MAX) ? TENT_MAX : r_tent + CW'(1);

  always_ff @(posedge clk) begin
    if (rst || !enable) r_estado <= IDLE;
    else                r_estado <= w_prox;
  end

  always_comb begin
    w_prox = r_estado;
    case (r_estado)
      IDLE:    if (digitos_valid && !w_especial) w_prox = CHECK;
      CHECK:   if (w_match) w_prox = ABERTO;
               else if (w_tent_inc == TENT_MAX) w_prox = BLOQ;
               else w_prox = IDLE;
      ABERTO:  if (r_timer == '0) w_prox = IDLE;
      BLOQ:    if (r_timer == '0) w_prox = IDLE;
      default: w_prox = IDLE;
    endcase
  end

  // The failure count survives a lockout so the next miss relocks at once.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      r_timer <= '0;
      r_latch <= {N_NIB{NIB_VAZIO}};
      r_tent  <= '0;
      r_bip   <= 1'b0;
      r_setup <= 1'b0;
    end else begin
      r_bip   <= 1'b0;
      r_setup <= 1'b0;
      case (r_estado)
        IDLE: begin
          if (digitos_valid && w_eh_cfg) r_setup <= 1'b1;
          if (digitos_valid && !w_especial) r_latch <= digitos_value;
        end
        CHECK: begin
          if (w_match) begin
            r_tent  <= '0;
            r_timer <= TW'(T_ABERTO - 1);
          end else begin
            r_bip  <= 1'b1;
            r_tent <= w_tent_inc;
            if (w_tent_inc == TENT_MAX) r_timer <= TW'(T_BLOQ - 1);
          end
        end
        ABERTO: begin
          if (digitos_valid && w_eh_cfg) r_setup <= 1'b1;
          if (r_timer != '0) r_timer <= r_timer - 1'b1;
        end
        BLOQ: begin
          if (r_timer != '0) r_timer <= r_timer - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    tranca_aberta = (r_estado == ABERTO);
    bloqueado     = (r_estado == BLOQ);
    bip           = r_bip;
    setup_req     = r_setup;
    tentativas    = r_tent;
  end

endmodule

// File: tb/tb_verificador_senha.sv
// tb/tb_verificador_senha.sv - scoreboard bench for verificador_senha
module tb_verificador_senha;
  import verificador_senha_pkg::*;

  localparam int NS    = 4;
  localparam int MIN_D = 4;
  localparam int MAX_D = 12;
  localparam int MAXT  = 3;
  localparam int TA    = 5000;
  localparam int TB    = 30000;

  localparam int EV_SETUP  = 0;
  localparam int EV_OPEN   = 1;
  localparam int EV_CLOSE  = 2;
  localparam int EV_BIP    = 3;
  localparam int EV_LOCK   = 4;
  localparam int EV_UNLOCK = 5;

  typedef struct {
    int kind;
    int cyc;
    int tent;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  logic enable;
  logic digitos_valid;
  senhaPac_t digitos_value;
  senhaPac_t [NS-1:0] senhas;
  logic [NS-1:0] senhas_ativas;
  logic tranca_aberta;
  logic bloqueado;
  logic bip;
  logic setup_req;
  logic [1:0] tentativas;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  ev_t q[$];
  bit mon_on = 1'b0;
  bit p_tr = 1'b0;
  bit p_bl = 1'b0;

  int m_tent = 0;
  int m_mode = 0;
  int m_end = 0;
  senhaPac_t pw0, pw_inat, wrong9, short123, gap;

  verificador_senha #(
    .N_SENHAS (NS), .MIN_DIG (MIN_D), .MAX_DIG (MAX_D),
    .MAX_TENT (MAXT), .T_ABERTO (TA), .T_BLOQ (TB)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .digitos_value (digitos_value),
    .digitos_valid (digitos_valid),
    .senhas        (senhas),
    .senhas_ativas (senhas_ativas),
    .tranca_aberta (tranca_aberta),
    .bloqueado     (bloqueado),
    .bip           (bip),
    .setup_req     (setup_req),
    .tentativas    (tentativas)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int dlen(input senhaPac_t v);
    for (int i = 0; i < 20; i++) if (v[i] == 4'hF) return i;
    return 20;
  endfunction

  function automatic bit uniform(input senhaPac_t v, input logic [3:0] n);
    for (int i = 0; i < 20; i++) if (v[i] != n) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit malformed(input senhaPac_t v);
    int used = 0;
    for (int i = 0; i < 20; i++) if (v[i] != 4'hF) used++;
    return (used != dlen(v)) || (dlen(v) < MIN_D) || (dlen(v) > MAX_D);
  endfunction

  function automatic bit accepted(input senhaPac_t v);
    if (malformed(v)) return 1'b0;
    for (int s = 0; s < NS; s++) if (senhas_ativas[s] && senhas[s] == v) return 1'b1;
    return 1'b0;
  endfunction

  function automatic senhaPac_t mk(input int len);
    senhaPac_t v = '1;
    for (int i = 0; i < len; i++) v[i] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  function automatic senhaPac_t mk_bad();
    senhaPac_t v;
    int l;
    case ($urandom_range(0, 2))
      0: v = mk(int'($urandom_range(1, 3)));
      1: v = mk(int'($urandom_range(13, 20)));
      default: begin
        l = int'($urandom_range(6, 12));
        v = mk(l);
        v[$urandom_range(1, l - 2)] = 4'hF;
      end
    endcase
    return v;
  endfunction

  task automatic push(input int kind, input int c, input int t);
    q.push_back('{kind, c, t});
  endtask

  task automatic got(input int kind);
    ev_t e;
    n_cmp++;
    if (q.size() == 0) begin
      n_bad++;
      $display("FAIL event: unexpected kind=%0d at cycle %0d tentativas=%0d, required none",
               kind, cyc, tentativas);
    end else begin
      e = q.pop_front();
      if (kind != e.kind || cyc != e.cyc || int'(tentativas) != e.tent) begin
        n_bad++;
        $display("FAIL event: got kind=%0d cycle=%0d tentativas=%0d, required kind=%0d cycle=%0d tentativas=%0d",
                 kind, cyc, tentativas, e.kind, e.cyc, e.tent);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (setup_req) got(EV_SETUP);
      if (bip) got(EV_BIP);
      if (tranca_aberta && !p_tr) got(EV_OPEN);
      if (!tranca_aberta && p_tr) got(EV_CLOSE);
      if (bloqueado && !p_bl) got(EV_LOCK);
      if (!bloqueado && p_bl) got(EV_UNLOCK);
      p_tr = tranca_aberta;
      p_bl = bloqueado;
    end
  end

  task automatic submit(input senhaPac_t v);
    int k;
    k = cyc;
    if (m_mode == 1) begin
      if (uniform(v, 4'hB)) push(EV_SETUP, k + 1, m_tent);
    end else if (m_mode == 0) begin
      if (uniform(v, 4'hB)) begin
        push(EV_SETUP, k + 1, m_tent);
      end else if (!uniform(v, 4'hE) && !uniform(v, 4'hF)) begin
        if (accepted(v)) begin
          m_tent = 0;
          push(EV_OPEN, k + 2, 0);
          m_mode = 1;
          m_end  = k + 2 + TA;
        end else begin
          m_tent = (m_tent < MAXT) ? m_tent + 1 : MAXT;
          push(EV_BIP, k + 2, m_tent);
          if (m_tent == MAXT) begin
            push(EV_LOCK, k + 2, m_tent);
            m_mode = 2;
            m_end  = k + 2 + TB;
          end
        end
      end
    end
    digitos_value = v;
    digitos_valid = 1'b1;
    @(posedge clk); #1;
    digitos_valid = 1'b0;
    digitos_value = '1;
    @(posedge clk); #1;
  endtask

  // d < 0 waits out the window; otherwise rst/enable cuts it after d cycles.
  task automatic finish(input int d, input bit use_en);
    if (m_mode == 0) return;
    if (d < 0 || cyc + d + 1 >= m_end) begin
      push((m_mode == 1) ? EV_CLOSE : EV_UNLOCK, m_end, (m_mode == 1) ? 0 : m_tent);
      while (cyc < m_end) begin @(posedge clk); #1; end
      @(posedge clk); #1;
    end else begin
      repeat (d) begin @(posedge clk); #1; end
      push((m_mode == 1) ? EV_CLOSE : EV_UNLOCK, cyc + 1, 0);
      if (use_en) enable = 1'b0; else rst = 1'b1;
      @(posedge clk); #1;
      enable = 1'b1;
      rst = 1'b0;
      m_tent = 0;
    end
    m_mode = 0;
  endtask

  task automatic do_rst(input bit use_en);
    if (use_en) enable = 1'b0; else rst = 1'b1;
    @(posedge clk); #1;
    enable = 1'b1;
    rst = 1'b0;
    m_tent = 0;
  endtask

  initial begin
    senhaPac_t v;
    int r;
    rst = 1'b1;
    enable = 1'b1;
    digitos_valid = 1'b0;
    digitos_value = '1;
    pw0 = '1;      pw0[3] = 4'd1; pw0[2] = 4'd2; pw0[1] = 4'd3; pw0[0] = 4'd4;
    wrong9 = '1;   for (int i = 0; i < 4; i++) wrong9[i] = 4'd9;
    short123 = '1; short123[2] = 4'd1; short123[1] = 4'd2; short123[0] = 4'd3;
    gap = '1;      gap[5] = 4'd1; gap[3] = 4'd3; gap[2] = 4'd4; gap[1] = 4'd5; gap[0] = 4'd6;
    pw_inat = mk(8);
    senhas[0] = pw0;
    senhas[1] = mk(6);
    senhas[2] = mk(12);
    senhas[3] = pw_inat;
    senhas_ativas = 4'b0111;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    n_cmp++;
    if ({tranca_aberta, bloqueado, bip, setup_req} != 4'b0 || tentativas != 2'd0) begin
      n_bad++;
      $display("FAIL reset: outputs=%b tentativas=%0d, required 0000 and 0",
               {tranca_aberta, bloqueado, bip, setup_req}, tentativas);
    end
    mon_on = 1'b1;

    submit({20{4'hE}});
    submit({20{4'hF}});
    submit({20{4'hB}});

    submit(pw0);
    submit({20{4'hB}});
    submit(wrong9);
    finish(-1, 1'b0);

    submit(short123);
    submit(gap);
    do_rst(1'b0);
    submit(pw_inat);
    do_rst(1'b1);

    repeat (3) submit(wrong9);
    submit(pw0);
    submit({20{4'hB}});
    submit({20{4'hE}});
    finish(-1, 1'b0);

    submit(wrong9);
    finish(-1, 1'b0);
    submit(pw0);
    finish(100, 1'b0);

    repeat (3) submit(wrong9);
    finish(50, 1'b1);

    for (int it = 0; it < 60; it++) begin
      r = int'($urandom_range(0, 99));
      if (r < 25)      v = senhas[$urandom_range(0, 2)];
      else if (r < 50) v = mk(int'($urandom_range(MIN_D, MAX_D)));
      else if (r < 65) v = mk_bad();
      else if (r < 75) v = pw_inat;
      else if (r < 90) begin
        case ($urandom_range(0, 2))
          0: v = {20{4'hB}};
          1: v = {20{4'hE}};
          default: v = {20{4'hF}};
        endcase
      end else begin
        do_rst(1'($urandom_range(0, 1)));
        continue;
      end
      submit(v);
      if (m_mode != 0) begin
        if ($urandom_range(0, 1) == 1) submit(($urandom_range(0, 1) == 1) ? {20{4'hB}} : pw0);
        finish(int'($urandom_range(1, 100)), 1'($urandom_range(0, 1)));
      end
    end

    repeat (5) begin @(posedge clk); #1; end
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL pending: %0d required events never seen, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
